vending_input_conditioner: RTL and testbench

Front-end stage of the vending machine: takes the three raw, asynchronous, bouncing front-panel inputs (coin slot switch, coffee button, sprite button) and produces clean, synchronous, single-cycle request pulses for the vending FSM's `i_coin`, `i_coffee` and `i_sprite` inputs. Each channel has a 2-FF synchronizer, a counter-based debouncer FSM and a press-edge detector. A fixed-priority arbiter guarantees that at most one request pulse is asserted per cycle, so the downstream FSM never sees simultaneous events.

---
 rtl/vending_input_conditioner.sv | 145 ++++++++++++++
 tb/tb_vending_input_conditioner.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/vending_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : vending_input_conditioner
// Description : Synchronizes, debounces and edge-detects three front-panel
//               inputs, then arbitrates them into one-hot request pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module vending_input_conditioner #(
    parameter int DB_CNT = 50000,
    parameter int CNT_W  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_coin_btn,
    input  logic       i_coffee_btn,
    input  logic       i_sprite_btn,
    output logic       o_coin,
    output logic       o_coffee,
    output logic       o_sprite,
    output logic [2:0] o_db_level
);

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'b00,
        ST_PRESS_WAIT   = 2'b01,
        ST_PRESSED      = 2'b10,
        ST_RELEASE_WAIT = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] c_db_last = CNT_W'(DB_CNT - 1);

    logic [2:0] w_btn;
    logic [2:0] w_set;
    logic [2:0] w_grant;
    logic [2:0] w_pend_nxt;
    logic [2:0] r_pend;
    logic [2:0] r_req;

    // Bit order everywhere: [0]=coin, [1]=coffee, [2]=sprite
    assign w_btn = {i_sprite_btn, i_coffee_btn, i_coin_btn};

    for (genvar i = 0; i < 3; i++) begin : g_ch
        logic             r_sync1;
        logic             r_sync2;
        state_t           r_state;
        state_t           w_state_nxt;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic             w_press_done;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
                r_state <= ST_RELEASED;
                r_cnt   <= '0;
            end else begin
                r_sync1 <= w_btn[i];
                r_sync2 <= r_sync1;
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
            end
        end

        always_comb begin
            w_state_nxt  = r_state;
            w_cnt_nxt    = r_cnt;
            w_press_done = 1'b0;
            case (r_state)
                ST_RELEASED: begin
                    if (r_sync2) begin
                        w_state_nxt = ST_PRESS_WAIT;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!r_sync2) begin
                        w_state_nxt = ST_RELEASED;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_db_last) begin
                        w_state_nxt  = ST_PRESSED;
                        w_cnt_nxt    = '0;
                        w_press_done = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (!r_sync2) begin
                        w_state_nxt = ST_RELEASE_WAIT;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_RELEASE_WAIT: begin
                    // A high here is release bounce: back to PRESSED silently
                    if (r_sync2) begin
                        w_state_nxt = ST_PRESSED;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_db_last) begin
                        w_state_nxt = ST_RELEASED;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_RELEASED;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        assign w_set[i]      = w_press_done;
        assign o_db_level[i] = (r_state == ST_PRESSED) || (r_state == ST_RELEASE_WAIT);
    end

    // Fixed priority coin > coffee > sprite; a same-cycle set overrides the clear
    always_comb begin
        w_grant = 3'b000;
        if (r_pend[0]) begin
            w_grant = 3'b001;
        end else if (r_pend[1]) begin
            w_grant = 3'b010;
        end else if (r_pend[2]) begin
            w_grant = 3'b100;
        end
        w_pend_nxt = (r_pend & ~w_grant) | w_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= 3'b000;
            r_req  <= 3'b000;
        end else begin
            r_pend <= w_pend_nxt;
            r_req  <= w_grant;
        end
    end

    assign o_coin   = r_req[0];
    assign o_coffee = r_req[1];
    assign o_sprite = r_req[2];

endmodule
`default_nettype wire

// File: tb/tb_vending_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_vending_input_conditioner
// Description : Self-checking bench: vector table plus hand-written sequences,
//               pulses checked against a queue of expected (channel, edge).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vending_input_conditioner;

    localparam int C_DB_CNT = 4;
    localparam int C_LAT    = C_DB_CNT + 3;

    logic       clk;
    logic       rst;
    logic       i_coin_btn;
    logic       i_coffee_btn;
    logic       i_sprite_btn;
    logic       o_coin;
    logic       o_coffee;
    logic       o_sprite;
    logic [2:0] o_db_level;

    int n_checks = 0;
    int n_errors = 0;
    int edge_n   = 0;

    typedef struct {
        int ch;
        int edge_no;
    } exp_t;

    exp_t exp_q[$];

    typedef struct {
        logic [2:0] btns;
        int         hold;
        int         ofs_coin;
        int         ofs_coffee;
        int         ofs_sprite;
        logic [2:0] lvl;
    } vec_t;

    vec_t vecs[7];

    vending_input_conditioner #(
        .DB_CNT (C_DB_CNT),
        .CNT_W  (16)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .i_coin_btn   (i_coin_btn),
        .i_coffee_btn (i_coffee_btn),
        .i_sprite_btn (i_sprite_btn),
        .o_coin       (o_coin),
        .o_coffee     (o_coffee),
        .o_sprite     (o_sprite),
        .o_db_level   (o_db_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic set_btns(input logic [2:0] b);
        i_coin_btn   = b[0];
        i_coffee_btn = b[1];
        i_sprite_btn = b[2];
    endtask

    task automatic push_exp(input int ch, input int e);
        exp_t x;
        x.ch      = ch;
        x.edge_no = e;
        exp_q.push_back(x);
    endtask

    function automatic int vec_ofs(input vec_t v, input int ch);
        case (ch)
            0:       return v.ofs_coin;
            1:       return v.ofs_coffee;
            default: return v.ofs_sprite;
        endcase
    endfunction

    // Pulse monitor: every observed pulse must match the head of the queue
    always @(negedge clk) begin
        logic [2:0] w;
        exp_t       x;
        w = {o_sprite, o_coffee, o_coin};
        if (w != 3'b000) begin
            check("one_hot", int'($onehot(w)), 1);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_pulse: got outputs %b at edge %0d, required none", w, edge_n);
            end else begin
                x = exp_q.pop_front();
                check("pulse_channel", int'(w), 1 << x.ch);
                check("pulse_edge", edge_n, x.edge_no);
            end
        end
    end

    initial begin
        int e0;
        vecs[0] = '{btns: 3'b010, hold: 20, ofs_coin: -1, ofs_coffee: 7,  ofs_sprite: -1, lvl: 3'b010};
        vecs[1] = '{btns: 3'b111, hold: 20, ofs_coin: 7,  ofs_coffee: 8,  ofs_sprite: 9,  lvl: 3'b111};
        vecs[2] = '{btns: 3'b100, hold: 3,  ofs_coin: -1, ofs_coffee: -1, ofs_sprite: -1, lvl: 3'b000};
        vecs[3] = '{btns: 3'b100, hold: 4,  ofs_coin: -1, ofs_coffee: -1, ofs_sprite: -1, lvl: 3'b000};
        vecs[4] = '{btns: 3'b100, hold: 5,  ofs_coin: -1, ofs_coffee: -1, ofs_sprite: 7,  lvl: 3'b100};
        vecs[5] = '{btns: 3'b101, hold: 10, ofs_coin: 7,  ofs_coffee: -1, ofs_sprite: 8,  lvl: 3'b101};
        vecs[6] = '{btns: 3'b110, hold: 12, ofs_coin: -1, ofs_coffee: 7,  ofs_sprite: 8,  lvl: 3'b110};

        // Reset with every button pressed
        rst = 1'b1;
        set_btns(3'b111);
        repeat (4) @(negedge clk);
        check("rst_outputs", int'({o_sprite, o_coffee, o_coin}), 0);
        check("rst_level", int'(o_db_level), 0);
        set_btns(3'b001);
        @(negedge clk);
        rst = 1'b0;
        push_exp(0, edge_n + 1 + C_LAT);
        repeat (15) @(negedge clk);
        check("post_rst_level", int'(o_db_level), 1);
        set_btns(3'b000);
        repeat (20) @(negedge clk);

        // Vector table
        foreach (vecs[k]) begin
            e0 = edge_n + 1;
            for (int ch = 0; ch < 3; ch++)
                if (vec_ofs(vecs[k], ch) >= 0) push_exp(ch, e0 + vec_ofs(vecs[k], ch));
            for (int c = 0; c < vecs[k].hold + 20; c++) begin
                if (c == 6)  check($sformatf("v%0d_level_pre", k), int'(o_db_level), 0);
                if (c == 7)  check($sformatf("v%0d_level_on", k), int'(o_db_level), int'(vecs[k].lvl));
                if (c == vecs[k].hold + 6)
                    check($sformatf("v%0d_level_hold", k), int'(o_db_level), int'(vecs[k].lvl));
                if (c == vecs[k].hold + 7)
                    check($sformatf("v%0d_level_off", k), int'(o_db_level), 0);
                set_btns((c < vecs[k].hold) ? vecs[k].btns : 3'b000);
                @(negedge clk);
            end
        end

        // Coin press bounce 1,0,1,0,1 then held, release bounce 0,1,0,1 then low
        for (int c = 0; c < 45; c++) begin
            logic v;
            if (c < 4)       v = (c % 2 == 0);
            else if (c < 19) v = 1'b1;
            else if (c < 23) v = ((c - 19) % 2 == 1);
            else             v = 1'b0;
            if (c == 4) push_exp(0, edge_n + 1 + C_LAT);
            if (c == 18) check("bounce_level", int'(o_db_level), 1);
            set_btns({2'b00, v});
            @(negedge clk);
        end

        // Reset after pend is set but before the pulse is registered
        e0 = edge_n + 1;
        set_btns(3'b001);
        repeat (7) @(negedge clk);
        check("midrst_pressed", int'(o_db_level), 1);
        rst = 1'b1;
        #1;
        check("midrst_level_clr", int'(o_db_level), 0);
        @(negedge clk);
        check("midrst_no_pulse", int'(o_coin), 0);
        rst = 1'b0;
        push_exp(0, edge_n + 1 + C_LAT);
        repeat (15) @(negedge clk);
        set_btns(3'b000);
        repeat (20) @(negedge clk);

        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
